// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: FSM encodings, register
// index width and the bundled stage-control word.
package pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_DRAIN    = 2'd2;
  localparam state_t ST_HALTED   = 2'd3;

  typedef struct packed {
    logic if_en;
    logic if_flush;
    logic id_en;
    logic id_bubble;
    logic exe_en;
    logic mem_en;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_FLOW   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam stage_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational RAW / load-use hazard detection against the ID/EX and EXE/MEM
// destination registers. With forwarding only a load in EXE needs a bubble.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             forward_en,
  input  logic [REG_W-1:0] EXE_dest,
  input  logic             EXE_WB_en,
  input  logic             EXE_MEM_R_en,
  input  logic [REG_W-1:0] MEM_dest,
  input  logic             MEM_WB_en,
  output logic             hz
);

  logic exe_match;
  logic mem_match;

  // Register zero is hard-wired, so it never creates a dependency.
  assign exe_match = (EXE_dest != REG_ZERO) &&
                     ((EXE_dest == src1) || (two_src && (EXE_dest == src2)));
  assign mem_match = (MEM_dest != REG_ZERO) &&
                     ((MEM_dest == src1) || (two_src && (MEM_dest == src2)));

  assign hz = forward_en ? (EXE_WB_en && EXE_MEM_R_en && exe_match)
                         : ((EXE_WB_en && exe_match) || (MEM_WB_en && mem_match));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline. Stage controls are
// decoded combinationally from the FSM state and the current hazard inputs.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             forward_en,
  input  logic [REG_W-1:0] EXE_dest,
  input  logic             EXE_WB_en,
  input  logic             EXE_MEM_R_en,
  input  logic [REG_W-1:0] MEM_dest,
  input  logic             MEM_WB_en,
  input  logic             Br_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             resume_req,
  output logic             IF_en,
  output logic             IF_flush,
  output logic             ID_en,
  output logic             ID_bubble,
  output logic             EXE_en,
  output logic             MEM_en,
  output logic             halted,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_dbg
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [DRN_W-1:0]  DRN_LOAD  = DRN_W'(DRAIN_CYCLES - 1);

  state_t             state, state_nxt;
  logic               ret_drain, ret_drain_nxt;
  logic [DRN_W-1:0]   drain_cnt, drain_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               hz;
  logic               ms;
  stage_ctrl_t        ctrl;

  hazard_detect u_hazard_detect (
    .src1         (src1),
    .src2         (src2),
    .two_src      (two_src),
    .forward_en   (forward_en),
    .EXE_dest     (EXE_dest),
    .EXE_WB_en    (EXE_WB_en),
    .EXE_MEM_R_en (EXE_MEM_R_en),
    .MEM_dest     (MEM_dest),
    .MEM_WB_en    (MEM_WB_en),
    .hz           (hz)
  );

  assign ms = mem_access && !mem_ready;

  function automatic stage_ctrl_t run_decode(input logic stall, input logic br,
                                             input logic haz, input logic halt);
    stage_ctrl_t c;
    c = CTRL_FLOW;
    if (stall) begin
      c = CTRL_FREEZE;
    end else if (br) begin
      c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    end else if (haz) begin
      c.if_en     = 1'b0;
      c.id_bubble = 1'b1;
    end else if (halt) begin
      c.if_en     = 1'b0;
      c.if_flush  = 1'b1;
      c.id_bubble = 1'b1;
    end
    return c;
  endfunction

  // While draining the PC only moves to capture a resolved branch target.
  function automatic stage_ctrl_t drain_decode(input logic stall, input logic br);
    stage_ctrl_t c;
    if (stall) c = CTRL_FREEZE;
    else       c = '{br, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    return c;
  endfunction

  always_comb begin
    ctrl = CTRL_FREEZE;
    case (state)
      ST_RUN:      ctrl = run_decode(ms, Br_taken, hz, halt_req);
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          if (ret_drain) ctrl = drain_decode(1'b0, Br_taken);
          else           ctrl = run_decode(1'b0, Br_taken, hz, halt_req);
        end
      end
      ST_DRAIN:    ctrl = drain_decode(ms, Br_taken);
      default:     ctrl = CTRL_FREEZE;
    endcase
  end

  // The ready cycle of a wait that interrupted a drain also counts as a drain step.
  always_comb begin
    state_nxt     = state;
    ret_drain_nxt = ret_drain;
    drain_nxt     = drain_cnt;
    case (state)
      ST_RUN: begin
        if (ms) begin
          state_nxt     = ST_MEM_WAIT;
          ret_drain_nxt = 1'b0;
        end else if (!Br_taken && !hz && halt_req) begin
          state_nxt = ST_DRAIN;
          drain_nxt = DRN_LOAD;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          if (!ret_drain) begin
            state_nxt = ST_RUN;
          end else if (drain_cnt == '0) begin
            state_nxt = ST_HALTED;
          end else begin
            state_nxt = ST_DRAIN;
            drain_nxt = drain_cnt - 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (ms) begin
          state_nxt     = ST_MEM_WAIT;
          ret_drain_nxt = 1'b1;
        end else if (drain_cnt == '0) begin
          state_nxt = ST_HALTED;
        end else begin
          drain_nxt = drain_cnt - 1'b1;
        end
      end
      default: begin
        if (resume_req && !halt_req) state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_RUN;
      ret_drain       <= 1'b0;
      drain_cnt       <= '0;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
      stall_cnt       <= '0;
    end else begin
      state     <= state_nxt;
      ret_drain <= ret_drain_nxt;
      drain_cnt <= drain_nxt;
      if (state == ST_MEM_WAIT && !mem_ready) begin
        if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_LAST) mem_timeout_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if ((state == ST_RUN || state == ST_MEM_WAIT) && !ctrl.if_en &&
          (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign IF_en     = ctrl.if_en;
  assign IF_flush  = ctrl.if_flush;
  assign ID_en     = ctrl.id_en;
  assign ID_bubble = ctrl.id_bubble;
  assign EXE_en    = ctrl.exe_en;
  assign MEM_en    = ctrl.mem_en;
  assign halted    = (state == ST_HALTED);
  assign state_dbg = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a table of single-cycle decode vectors in
// RUN plus hand-written multi-cycle sequences for stalls, timeout and halt.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] src1, src2, EXE_dest, MEM_dest;
  logic       two_src, forward_en, EXE_WB_en, EXE_MEM_R_en, MEM_WB_en;
  logic       Br_taken, mem_access, mem_ready, halt_req, resume_req;
  logic       IF_en, IF_flush, ID_en, ID_bubble, EXE_en, MEM_en;
  logic       halted, mem_timeout_err;
  logic [3:0] stall_cnt;
  logic [1:0] state_dbg;
  logic [5:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .DRAIN_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2), .two_src(two_src),
    .forward_en(forward_en), .EXE_dest(EXE_dest), .EXE_WB_en(EXE_WB_en),
    .EXE_MEM_R_en(EXE_MEM_R_en), .MEM_dest(MEM_dest), .MEM_WB_en(MEM_WB_en),
    .Br_taken(Br_taken), .mem_access(mem_access), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume_req(resume_req), .IF_en(IF_en),
    .IF_flush(IF_flush), .ID_en(ID_en), .ID_bubble(ID_bubble), .EXE_en(EXE_en),
    .MEM_en(MEM_en), .halted(halted), .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign outs = {IF_en, IF_flush, ID_en, ID_bubble, EXE_en, MEM_en};

  localparam logic [5:0] O_FLOW   = 6'b101011;
  localparam logic [5:0] O_HZ     = 6'b001111;
  localparam logic [5:0] O_BR     = 6'b111111;
  localparam logic [5:0] O_FREEZE = 6'b000000;
  localparam logic [5:0] O_HALT   = 6'b011111;

  typedef struct {
    string      name;
    logic [4:0] s1, s2;
    logic       ts, fw;
    logic [4:0] ed;
    logic       ew, emr;
    logic [4:0] md;
    logic       mw, br, ma, mr, h;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    src1 = 0; src2 = 0; two_src = 0; forward_en = 0; EXE_dest = 0;
    EXE_WB_en = 0; EXE_MEM_R_en = 0; MEM_dest = 0; MEM_WB_en = 0;
    Br_taken = 0; mem_access = 0; mem_ready = 0; halt_req = 0; resume_req = 0;
  endtask

  task automatic set_load_use();
    forward_en = 1; EXE_WB_en = 1; EXE_MEM_R_en = 1; EXE_dest = 5; src1 = 5;
  endtask

  task automatic apply(input vec_t v);
    src1 = v.s1; src2 = v.s2; two_src = v.ts; forward_en = v.fw;
    EXE_dest = v.ed; EXE_WB_en = v.ew; EXE_MEM_R_en = v.emr;
    MEM_dest = v.md; MEM_WB_en = v.mw; Br_taken = v.br;
    mem_access = v.ma; mem_ready = v.mr; halt_req = v.h; resume_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  initial begin
    //           name               s1 s2 ts fw ed ew emr md mw br ma mr h  exp
    vecs[0]  = '{"idle",            0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, O_FLOW};
    vecs[1]  = '{"load_use",        5, 0, 0, 1, 5, 1, 1,  0, 0, 0, 0, 0, 0, O_HZ};
    vecs[2]  = '{"fwd_no_load",     5, 0, 0, 1, 5, 1, 0,  0, 0, 0, 0, 0, 0, O_FLOW};
    vecs[3]  = '{"src2_unused",     0, 5, 0, 1, 5, 1, 1,  0, 0, 0, 0, 0, 0, O_FLOW};
    vecs[4]  = '{"src2_load_use",   0, 5, 1, 1, 5, 1, 1,  0, 0, 0, 0, 0, 0, O_HZ};
    vecs[5]  = '{"raw_mem_nofwd",   0, 7, 1, 0, 0, 0, 0,  7, 1, 0, 0, 0, 0, O_HZ};
    vecs[6]  = '{"r0_no_stall",     0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, O_FLOW};
    vecs[7]  = '{"fwd_ignores_mem", 7, 0, 0, 1, 0, 0, 0,  7, 1, 0, 0, 0, 0, O_FLOW};
    vecs[8]  = '{"raw_exe_nofwd",   3, 0, 0, 0, 3, 1, 0,  0, 0, 0, 0, 0, 0, O_HZ};
    vecs[9]  = '{"raw_wb_off",      3, 0, 0, 0, 3, 0, 0,  3, 0, 0, 0, 0, 0, O_FLOW};
    vecs[10] = '{"br_over_hz",      5, 0, 0, 1, 5, 1, 1,  0, 0, 1, 0, 0, 0, O_BR};
    vecs[11] = '{"ms_over_br",      0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, O_FREEZE};
    vecs[12] = '{"mem_done",        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, O_FLOW};
    vecs[13] = '{"halt_decode",     0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, O_HALT};
    vecs[14] = '{"hz_over_halt",    5, 0, 0, 1, 5, 1, 1,  0, 0, 0, 0, 0, 1, O_HZ};
    vecs[15] = '{"br_alone",        0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, O_BR};

    set_idle();
    rst_n = 0;
    #1;
    check("rst_state", state_dbg, 2'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_err", mem_timeout_err, 1'b0);
    check("rst_stall_cnt", stall_cnt, 4'd0);
    check("rst_idle_decode", outs, O_FLOW);
    set_load_use();
    #1;
    check("rst_hz_decode", outs, O_HZ);
    set_idle();
    #2;
    rst_n = 1;

    // decode table, inputs returned to idle before each edge
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check(vecs[i].name, outs, vecs[i].exp);
      check("vec_not_halted", halted, 1'b0);
      set_idle();
    end
    step();
    check("vec_state_run", state_dbg, 2'd0);
    check("vec_stall_cnt", stall_cnt, 4'd0);

    // load-use costs one bubble cycle
    do_reset();
    set_load_use();
    #1;
    check("lu_bubble", outs, O_HZ);
    step();
    set_idle();
    #1;
    check("lu_release", outs, O_FLOW);
    check("lu_stall_cnt", stall_cnt, 4'd1);

    // three-cycle memory stall, advance on ready
    do_reset();
    mem_access = 1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check("ms_freeze", outs, O_FREEZE);
      step();
      check("ms_stall_cnt", stall_cnt, 4'(i));
    end
    check("ms_state_wait", state_dbg, 2'd1);
    mem_ready = 1;
    #1;
    check("ms_ready_flow", outs, O_FLOW);
    step();
    check("ms_back_run", state_dbg, 2'd0);
    check("ms_final_cnt", stall_cnt, 4'd3);
    check("ms_no_err", mem_timeout_err, 1'b0);

    // timeout after 4 wait cycles, sticky
    do_reset();
    mem_access = 1;
    step();
    repeat (3) step();
    check("to_not_yet", mem_timeout_err, 1'b0);
    step();
    check("to_set", mem_timeout_err, 1'b1);
    check("to_still_wait", state_dbg, 2'd1);
    mem_ready = 1;
    step();
    check("to_back_run", state_dbg, 2'd0);
    set_idle();
    step();
    check("to_sticky", mem_timeout_err, 1'b1);

    // halt with a 2-cycle memory stall mid-drain: 7 edges to halted
    do_reset();
    halt_req = 1;
    #1;
    check("h_req_decode", outs, O_HALT);
    step();                                       // edge 1
    check("h_in_drain", state_dbg, 2'd2);
    halt_req = 0;
    #1;
    check("h_drain_decode", outs, O_HALT);
    Br_taken = 1;
    #1;
    check("h_drain_br", outs, O_BR);
    Br_taken = 0;
    step();                                       // edge 2
    mem_access = 1;
    step();                                       // edge 3
    check("h_drain_wait", state_dbg, 2'd1);
    step();                                       // edge 4
    mem_ready = 1;
    #1;
    check("h_ready_drain_decode", outs, O_HALT);
    step();                                       // edge 5
    check("h_resume_drain", state_dbg, 2'd2);
    mem_access = 0; mem_ready = 0;
    step();                                       // edge 6
    check("h_edge6", halted, 1'b0);
    step();                                       // edge 7
    check("h_edge7", halted, 1'b1);
    check("h_halted_ctrl", outs, O_FREEZE);
    halt_req = 1; resume_req = 1;
    step();
    check("h_both_stay", halted, 1'b1);
    halt_req = 0;
    step();
    resume_req = 0;
    check("h_resumed", halted, 1'b0);
    check("h_resume_state", state_dbg, 2'd0);
    #1;
    check("h_resume_flow", outs, O_FLOW);

    // reset mid-drain
    do_reset();
    halt_req = 1;
    step();
    halt_req = 0;
    check("rd_cnt_halt_cycle", stall_cnt, 4'd1);
    step();
    check("rd_in_drain", state_dbg, 2'd2);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rd_state", state_dbg, 2'd0);
    check("rd_cnt", stall_cnt, 4'd0);
    check("rd_flow", outs, O_FLOW);
    #1;
    rst_n = 1;
    repeat (5) step();
    check("rd_no_halt", halted, 1'b0);
    check("rd_run", state_dbg, 2'd0);

    // stall counter saturates at all-ones
    do_reset();
    set_load_use();
    repeat (18) step();
    check("sat_cnt", stall_cnt, 4'hF);
    set_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Stall/flush/halt sequencer for the 5-stage MIPS pipeline. Drives the enable and clear controls of the PC, IF/ID, ID/EX, EXE/MEM and MEM/WB stage registers. Detects load-use and RAW hazards from the ID/EX and EXE/MEM register outputs and freezes the pipeline while the multi-cycle data memory is busy. Provides a drain-and-halt sequence for debug, plus a saturating stall-cycle counter.

## Interface
- MEM_TIMEOUT, 255: MEM_WAIT cycles before `mem_timeout_err` sets.
- DRAIN_CYCLES, 4: cycles spent in DRAIN before HALTED (≥1).
- CNT_W, 16: width of `stall_cnt`.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- src1, src2  in  5  ID-stage source register numbers.
- two_src  in  1  ID instruction reads src2.
- forward_en  in  1  forwarding unit active.
- EXE_dest  in  5  ID/EX `dest` output.
- EXE_WB_en, EXE_MEM_R_en  in  1  ID/EX control outputs.
- MEM_dest  in  5  EXE/MEM `dest` output.
- MEM_WB_en  in  1  EXE/MEM control output.
- Br_taken  in  1  taken branch resolved in EXE.
- mem_access  in  1  MEM stage issues a read or write this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- halt_req, resume_req  in  1  debug level requests.
- IF_en  out  1  PC and IF/ID load enable.
- IF_flush  out  1  IF/ID loads a NOP.
- ID_en  out  1  ID/EX load enable.
- ID_bubble  out  1  ID/EX loads zeroed control fields (WB/MEM_R/MEM_W/Br_taken = 0).
- EXE_en, MEM_en  out  1  EXE/MEM and MEM/WB load enables.
- halted  out  1  pipeline in HALTED.
- mem_timeout_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  saturating stall-cycle count.

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED. Registered: state, return-state bit, drain counter, wait counter, `mem_timeout_err`, `stall_cnt`. All stage-control outputs are combinational from state and current inputs.
- Hazard `hz`:
  - Define `m(d)` = (d≠0) && (d==src1 || (two_src && d==src2)).
  - forward_en=1: `hz` = EXE_WB_en && EXE_MEM_R_en && m(EXE_dest).
  - forward_en=0: `hz` = (EXE_WB_en && m(EXE_dest)) || (MEM_WB_en && m(MEM_dest)).
- Memory stall `ms` = mem_access && !mem_ready.
- RUN priority is ms > Br_taken > hz > halt_req.
  - ms: all enables 0, no flush/bubble. Next state MEM_WAIT, return=RUN.
  - Br_taken: all enables 1, IF_flush=1, ID_bubble=1.
  - hz: IF_en=0; ID_en/EXE_en/MEM_en=1; ID_bubble=1.
  - halt_req: enables 1, IF_en=0, IF_flush=1, ID_bubble=1. Next state DRAIN, drain counter loads DRAIN_CYCLES-1.
  - Otherwise all enables 1, flush/bubble 0.
- MEM_WAIT:
  - All enables 0.
  - Wait counter increments each cycle; on reaching MEM_TIMEOUT, `mem_timeout_err`←1. It stays set until reset and does not change state.
  - mem_ready=1: outputs as in the return state for this cycle, except ms is treated as 0. Next state is the return state. Wait counter clears.
- DRAIN:
  - IF_flush=1, ID_bubble=1, ID_en/EXE_en/MEM_en=1. IF_en=Br_taken, so the PC captures the branch target.
  - ms → MEM_WAIT, return=DRAIN, drain counter frozen.
  - Otherwise the counter decrements; at 0 → HALTED.
  - halt_req is ignored here.
- HALTED:
  - All enables 0, halted=1.
  - resume_req → RUN. halt_req and resume_req both high → stay HALTED.
- `stall_cnt` increments (saturating at all-ones) each cycle in RUN or MEM_WAIT where IF_en=0. DRAIN and HALTED cycles are not counted.

## Timing
- Reset (rst_n=0, async): state RUN, counters 0, mem_timeout_err=0, stall_cnt=0, halted=0.
- Stage outputs during reset follow RUN decode of the inputs. With idle inputs this is all enables 1, flush/bubble 0.
- Stall and flush decisions take effect in the same cycle; state changes at the next edge.
- Load-use with forwarding costs exactly 1 bubble cycle.
- Without forwarding, a dependency costs up to 2 bubble cycles.
- A memory stall of N cycles freezes all stages for N cycles. The completing cycle advances normally.
- Halt latency: halt_req high in RUN → halted=1 after DRAIN_CYCLES+1 edges, plus any MEM_WAIT cycles.
- Reset mid-MEM_WAIT or mid-DRAIN returns to RUN immediately. No partial drain is retained.

## Structure
- Shared package `pipe_pkg`: state enum (RUN, MEM_WAIT, DRAIN, HALTED), register-zero constant, reg-index width 5.
- Natural sub-module: `hazard_detect`, the combinational `hz` computation, reusable by a forwarding unit.

## Test plan
- Load-use: EXE_MEM_R_en=1, EXE_WB_en=1, EXE_dest=5, src1=5, forward_en=1 → one cycle with IF_en=0, ID_bubble=1; next cycle all enables 1.
- No-forward RAW: forward_en=0, MEM_WB_en=1, MEM_dest=7, two_src=1, src2=7 → IF_en=0, ID_bubble=1. EXE_dest=0 with src1=0 → no stall.
- Memory stall: mem_access=1, mem_ready=0 for 3 cycles, then 1 → all enables 0 for 3 cycles; stall_cnt goes 0→3; advance on the ready cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → mem_timeout_err=1 after 4 wait cycles; stays 1 after mem_ready.
- Simultaneous Br_taken and hz → IF_en=1, IF_flush=1, ID_bubble=1. Br_taken with ms → full freeze, no flush.
- Halt/resume: halt_req pulse, DRAIN_CYCLES=4, with ms for 2 cycles mid-drain → halted=1 after 7 edges; resume_req → RUN, enables 1. Reset asserted mid-DRAIN → RUN, counters 0.
